// File: rtl/oneshot_sched.sv
// oneshot_sched: multi-channel one-shot trigger scheduler.
// Each channel fires once per high level and queues one pending event.
// Pending events are issued as 1-clock pulses with a channel id, round-robin,
// and separated by GAP idle cycles.
// Optional macro ONESHOT_SCHED_OVFCNT_EN adds per-channel 8-bit saturating
// overflow counters on port ovf_count.
module oneshot_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned IDW = 2,
  parameter int unsigned GAP = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NCH-1:0]   trig,
  input  logic             enable,
  input  logic             clear_ovf,
  output logic             pulse_out,
  output logic [IDW-1:0]   pulse_id,
  output logic             busy,
  output logic [NCH-1:0]   overflow
`ifdef ONESHOT_SCHED_OVFCNT_EN
  ,
  output logic [NCH*8-1:0] ovf_count
`endif
);

  localparam int unsigned GW = 4;
  localparam int unsigned CW = 8;

  typedef enum logic {S_IDLE, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   armed_q, armed_d;
  logic [NCH-1:0]   ovf_q, ovf_d;
  logic             pulse_q, pulse_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             busy_q, busy_d;

  logic [NCH-1:0]   detect;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   ovf_set;
  logic             found;
  logic             issue;
  logic [IDW-1:0]   sel;
  int unsigned      idx;

`ifdef ONESHOT_SCHED_OVFCNT_EN
  logic [CW-1:0]    cnt_q [NCH];
  logic [CW-1:0]    cnt_d [NCH];
`endif

  // Round-robin pick: first pending channel at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = 32'(rr_q) + 32'(k);
      if (idx >= NCH) idx = idx - NCH;
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  // Detector, pending/overflow bookkeeping and scheduler next state.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    rr_d    = rr_q;
    pulse_d = 1'b0;
    id_d    = id_q;

    // Armed exactly when the input was low last cycle: a level fires once.
    detect  = armed_q & trig;
    armed_d = ~trig;

    issue   = (state_q == S_IDLE) && enable && found;
    grant   = issue ? (NCH'(1) << sel) : '0;
    // A detect on a channel being granted this edge re-pends without loss.
    ovf_set = detect & pend_q & ~grant;
    pend_d  = (pend_q & ~grant) | detect;
    ovf_d   = (clear_ovf ? '0 : ovf_q) | ovf_set;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          pulse_d = 1'b1;
          id_d    = sel;
          rr_d    = (32'(sel) == NCH - 1) ? '0 : sel + IDW'(1);
          if (GAP > 0) begin
            gap_d   = GW'(GAP);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (|pend_d) || (state_d != S_IDLE);
  end

`ifdef ONESHOT_SCHED_OVFCNT_EN
  // Saturating per-channel overflow counters; a same-edge clear keeps the new event.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_ovf) cnt_d[i] = ovf_set[i] ? CW'(1) : '0;
      else if (ovf_set[i] && (cnt_q[i] != {CW{1'b1}})) cnt_d[i] = cnt_q[i] + CW'(1);
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    ovf_count = '0;
    for (int i = 0; i < NCH; i++) ovf_count[i*CW +: CW] = cnt_q[i];
  end
`endif

  // State register; reset truncates any pulse and discards pending work.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      rr_q    <= '0;
      pend_q  <= '0;
      armed_q <= '1;
      ovf_q   <= '0;
      pulse_q <= 1'b0;
      id_q    <= '0;
      busy_q  <= 1'b0;
`ifdef ONESHOT_SCHED_OVFCNT_EN
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
`ifdef ONESHOT_SCHED_OVFCNT_EN
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
`endif
    end
  end

  assign pulse_out = pulse_q;
  assign pulse_id  = id_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_oneshot_sched.sv
// Bench for oneshot_sched: scoreboard of expected pulse ids, popped on each
// issued pulse; timing, busy and overflow checked against fixed expectations.
module tb_oneshot_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] trig;
  logic [3:0] trig_g0;
  logic       enable;
  logic       clear_ovf;

  logic       pulse_out, pulse_out_g0;
  logic [1:0] pulse_id, pulse_id_g0;
  logic       busy, busy_g0;
  logic [3:0] overflow, overflow_g0;
`ifdef ONESHOT_SCHED_OVFCNT_EN
  logic [31:0] ovf_count, ovf_count_g0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [1:0] exp_q[$];
  logic [1:0] exp_g0_q[$];
  int         pcyc_q[$];
  int         pcyc_g0_q[$];

  oneshot_sched #(.NCH(4), .IDW(2), .GAP(2)) u_dut (
    .clock(clk), .reset_n(rst_n), .trig(trig), .enable(enable),
    .clear_ovf(clear_ovf), .pulse_out(pulse_out), .pulse_id(pulse_id),
    .busy(busy), .overflow(overflow)
`ifdef ONESHOT_SCHED_OVFCNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  oneshot_sched #(.NCH(4), .IDW(2), .GAP(0)) u_dut_g0 (
    .clock(clk), .reset_n(rst_n), .trig(trig_g0), .enable(enable),
    .clear_ovf(clear_ovf), .pulse_out(pulse_out_g0), .pulse_id(pulse_id_g0),
    .busy(busy_g0), .overflow(overflow_g0)
`ifdef ONESHOT_SCHED_OVFCNT_EN
    , .ovf_count(ovf_count_g0)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: every issued pulse must match the next expected id.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pulse_out === 1'b1) begin
      pcyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("unexp_pulse", 32'(pulse_id), 32'hdead);
      else chk("pulse_id", 32'(pulse_id), 32'(exp_q.pop_front()));
    end
    if (rst_n === 1'b1 && pulse_out_g0 === 1'b1) begin
      pcyc_g0_q.push_back(cyc);
      if (exp_g0_q.size() == 0) chk("unexp_pulse_g0", 32'(pulse_id_g0), 32'hdead);
      else chk("pulse_id_g0", 32'(pulse_id_g0), 32'(exp_g0_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (exp_q.size() == 0 && exp_g0_q.size() == 0) break;
    end
    if (exp_q.size() != 0 || exp_g0_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size() + exp_g0_q.size()), 32'd0);
      exp_q.delete();
      exp_g0_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trig = '0;
    trig_g0 = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    exp_q.delete();
    exp_g0_q.delete();
    pcyc_q.delete();
    pcyc_g0_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int last;
    bit seen;

    // Reset values, with a trigger already high at release.
    rst_n = 1'b0; trig = 4'b0001; trig_g0 = '0; enable = 1'b1; clear_ovf = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_pulse_out", 32'(pulse_out), 32'd0);
    chk("rst_pulse_id", 32'(pulse_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    r = cyc;
    exp_q.push_back(2'd0);
    wait_drain(10);
    if (pcyc_q.size() > 0) chk("latency", 32'(pcyc_q[0] - r), 32'd2);
    tick(10);
    chk("held_level_once", 32'(pcyc_q.size()), 32'd1);
    trig = '0;
    tick(2);
    trig = 4'b0001;
    exp_q.push_back(2'd0);
    wait_drain(10);
    tick(4);
    trig = '0;
    chk("rearm_second", 32'(pcyc_q.size()), 32'd2);

    // All four channels at once, GAP=2: ids 0..3, 3 cycles apart.
    do_reset();
    trig = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(2'(i));
    wait_drain(40);
    chk("rr_count", 32'(pcyc_q.size()), 32'd4);
    if (pcyc_q.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("gap_spacing", 32'(pcyc_q[i] - pcyc_q[i-1]), 32'd3);
      last = pcyc_q[3];
      @(negedge clk);
      chk("busy_cyc", 32'(cyc - last), 32'd1);
      chk("busy_after_pulse", 32'(busy), 32'd1);
      @(negedge clk);
      chk("busy_fall", 32'(busy), 32'd0);
    end
    chk("no_ovf_held", 32'(overflow), 32'd0);
    trig = '0;
    tick(2);

    // GAP=0 instance: back-to-back pulses.
    trig_g0 = 4'b0011;
    exp_g0_q.push_back(2'd0);
    exp_g0_q.push_back(2'd1);
    wait_drain(10);
    chk("g0_count", 32'(pcyc_g0_q.size()), 32'd2);
    if (pcyc_g0_q.size() == 2) chk("g0_b2b", 32'(pcyc_g0_q[1] - pcyc_g0_q[0]), 32'd1);
    trig_g0 = '0;
    tick(2);

    // enable=0 with a repeated trigger: overflow, no pulse, merged event.
    pcyc_q.delete();
    enable = 1'b0;
    trig = 4'b0100; tick(2);
    trig = 4'b0000; tick(2);
    trig = 4'b0100; tick(2);
    trig = 4'b0000;
    @(negedge clk);
    chk("ovf_ch2", 32'(overflow), 32'h4);
    chk("hold_no_pulse", 32'(pcyc_q.size()), 32'd0);
    chk("busy_pending", 32'(busy), 32'd1);
    enable = 1'b1;
    exp_q.push_back(2'd2);
    wait_drain(10);
    tick(4);
    chk("merged_one_pulse", 32'(pcyc_q.size()), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'h4);
    clear_ovf = 1'b1; tick(1); clear_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clear", 32'(overflow), 32'h0);

    // Same-edge overflow set and clear: set wins.
    enable = 1'b0;
    trig = 4'b0010; tick(2);
    trig = 4'b0000; tick(2);
    trig = 4'b0010; clear_ovf = 1'b1; tick(1); clear_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", 32'(overflow), 32'h2);
`ifdef ONESHOT_SCHED_OVFCNT_EN
    chk("cnt_set_clear", 32'(ovf_count[15:8]), 32'd1);
`endif
    trig = '0;
    enable = 1'b1;
    exp_q.push_back(2'd1);
    wait_drain(10);
    clear_ovf = 1'b1; tick(1); clear_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_clear2", 32'(overflow), 32'h0);

    // Reset during a pulse: truncated at once, pending channel 0 dropped.
    pcyc_q.delete();
    trig = 4'b1001;
    exp_q.push_back(2'd3);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pulse_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("pulse_seen", 32'(seen), 32'd1);
    #1;
    rst_n = 1'b0;
    trig = '0;
    #1;
    chk("rst_trunc", 32'(pulse_out), 32'd0);
    chk("rst_busy_mid", 32'(busy), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(15);
    chk("no_pulse_after_rst", 32'(pcyc_q.size()), 32'd1);
    chk("rr_rst_queue", 32'(exp_q.size()), 32'd0);

`ifdef ONESHOT_SCHED_OVFCNT_EN
    // 300 overflow events on channel 1 saturate its counter.
    do_reset();
    enable = 1'b0;
    trig = 4'b0010; tick(1);
    for (int i = 0; i < 300; i++) begin
      trig = 4'b0000; tick(1);
      trig = 4'b0010; tick(1);
    end
    trig = '0;
    @(negedge clk);
    chk("cnt_sat", 32'(ovf_count[15:8]), 32'd255);
    chk("cnt_other", 32'(ovf_count[7:0]), 32'd0);
    chk("cnt_flag", 32'(overflow), 32'h2);
    clear_ovf = 1'b1; tick(1); clear_ovf = 1'b0;
    @(negedge clk);
    chk("cnt_clear", 32'(ovf_count[15:8]), 32'd0);
    enable = 1'b1;
    exp_q.push_back(2'd1);
    wait_drain(10);
`endif

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oneshot_sched.md
Name: oneshot_sched

Overview:
- Multi-channel one-shot scheduler.
- Edge-detects NCH level triggers with one-shot semantics: fire once on a high level, re-arm only after the input goes low.
- Queues one pending event per channel and issues events onto a single shared 1-clock pulse line with a channel ID, using round-robin arbitration and an enforced minimum gap.
- Sits between raw trigger sources and a downstream consumer that can only accept one pulse at a time.

Parameters:
- NCH, 4, number of trigger channels (2..16).
- IDW, 2, width of pulse_id; must satisfy 2**IDW >= NCH.
- GAP, 2, idle cycles forced between consecutive issued pulses (0..15).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- trig  in  NCH  per-channel trigger levels; synchronous to clock.
- enable  in  1  issue enable; 0 holds all pending events, no pulses issued.
- clear_ovf  in  1  synchronous clear of overflow flags.
- pulse_out  out  1  registered 1-clock pulse, one per issued event.
- pulse_id  out  IDW  channel of the current pulse; valid only while pulse_out=1.
- busy  out  1  registered; high if any event is pending or the scheduler is not in S_IDLE.
- overflow  out  NCH  sticky per-channel lost-event flags.

Behaviour:
- Reset (async assert, clocked release):
  - pulse_out=0, pulse_id=0, busy=0, overflow=0.
  - All pending=0, all channels armed, scheduler S_IDLE, round-robin pointer=0.
  - A trig already high at reset release is detected on the first clock edge.
- Per-channel detector, two states:
  - ARMED: trig[i]=1 → detect (set pending[i]), go DISARMED.
  - DISARMED: trig[i]=0 → ARMED.
  - A high level held for any length yields exactly one event.
- Overflow: detect while pending[i]=1 → overflow[i]<=1; pending stays 1, so events merge.
- Same-edge grant and new detect on the same channel: pending[i] stays 1; no overflow.
- clear_ovf: clears all overflow bits at the next edge. A same-edge overflow set wins over the clear for that bit.
- Scheduler FSM:
  - S_IDLE: if enable and any pending, select the first pending channel at or after rr_ptr (wrapping modulo NCH). At the edge:
    - pulse_out<=1, pulse_id<=sel, pending[sel]<=0, rr_ptr<=sel+1 (wrap to 0 at NCH).
    - If GAP>0: gap_cnt<=GAP and go S_GAP. If GAP=0: stay S_IDLE, so back-to-back pulses are allowed.
  - Otherwise pulse_out<=0.
  - S_GAP: pulse_out<=0; gap_cnt decrements each cycle. On the edge where gap_cnt==1, go S_IDLE.
- Timing:
  - Successive rising edges of pulse_out are at least GAP+1 cycles apart.
  - Latency: trig rises before edge k → pending at edge k → pulse_out high after edge k+1, if idle and enabled.
- enable:
  - enable=0 in S_IDLE: no issue; pending and overflow continue to update.
  - Deassert during S_GAP: the gap completes, then the FSM waits in S_IDLE.
- Fairness: with all channels permanently pending, each channel is issued exactly once per NCH pulses.
- Reset mid-operation: any in-flight pulse is truncated immediately; pending events and the gap are discarded.

Optional Feature:
- Macro: ONESHOT_SCHED_OVFCNT_EN.
- Defined:
  - Adds output port ovf_count (NCH*8 bits).
  - One 8-bit saturating counter per channel, incremented on each overflow event and held at 255.
  - Cleared by clear_ovf and by reset. A same-edge increment and clear leaves the count at 1.
- Undefined: port and counters absent; only the sticky overflow flags exist.

Test Plan:
- Reset release with trig=0001 held high 10 cycles → exactly one pulse, pulse_id=0; trig low then high again → second pulse.
- trig=1111 rising together, GAP=2, enable=1 → pulses with ids 0,1,2,3, rising edges exactly 3 cycles apart; busy falls 1 cycle after the last pulse.
- GAP=0, trig=0011 together → pulses on two consecutive cycles, ids 0 then 1.
- enable=0, trig[2] pulsed twice (high-low-high) → overflow=0100, no pulse_out; enable=1 → one pulse id=2; clear_ovf → overflow=0000.
- reset_n asserted during the pulse_out high cycle → pulse_out low immediately; no pulses after release while trig=0.
- With ONESHOT_SCHED_OVFCNT_EN: 300 overflow events on channel 1 → ovf_count[15:8]=255; clear_ovf → 0.
